// File: rtl/maze_path_stack_if.sv
// maze_path_stack_if: solver-side push/pop/run and replay valid/ready handshake bundle
interface maze_path_stack_if;
    logic       push;
    logic       pop;
    logic [1:0] dir_in;
    logic       run;
    logic       dir_ready;
    logic [1:0] dir_out;
    logic       dir_valid;
    logic       replay_done;

    modport master (
        output push, pop, dir_in, run, dir_ready,
        input  dir_out, dir_valid, replay_done
    );

    modport slave (
        input  push, pop, dir_in, run, dir_ready,
        output dir_out, dir_valid, replay_done
    );
endinterface

// File: rtl/maze_path_stack.sv
// maze_path_stack: LIFO of solver moves, replayed oldest-first over valid/ready once solving is done
module maze_path_stack #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    maze_path_stack_if.slave   bus,
    output logic [ADDR_W:0]    count,
    output logic               empty,
    output logic               full,
    output logic               ovf
);
    typedef enum logic [1:0] {RECORD, REPLAY, FINISH} state_t;

    state_t            state, state_d;
    logic [ADDR_W:0]   sp, sp_d;
    logic [ADDR_W-1:0] rp, rp_d, top, wa;
    logic              ovf_d, we;
    logic [1:0]        mem [DEPTH];

    // sp carries one extra bit so a completely full stack is distinguishable from empty
    assign count = sp;
    assign empty = (sp == '0);
    assign full  = sp[ADDR_W];
    assign top   = sp[ADDR_W-1:0] - 1'b1;

    // state, pointers and sticky overflow; reset aborts any replay immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RECORD;
            sp    <= '0;
            rp    <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_d;
            sp    <= sp_d;
            rp    <= rp_d;
            ovf   <= ovf_d;
        end
    end

    // register-array storage; contents survive reset and clear
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= bus.dir_in;
    end

    // next-state, pointer updates and handshake outputs with clr > run > push/pop priority
    always_comb begin
        state_d         = state;
        sp_d            = sp;
        rp_d            = rp;
        ovf_d           = ovf;
        we              = 1'b0;
        wa              = sp[ADDR_W-1:0];
        bus.dir_valid   = (state == REPLAY);
        bus.replay_done = (state == FINISH);
        bus.dir_out     = (state == REPLAY) ? mem[rp] : 2'd0;
        if (clr) begin
            state_d = RECORD;
            sp_d    = '0;
            rp_d    = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state)
                RECORD: begin
                    if (bus.run) begin
                        rp_d    = '0;
                        state_d = empty ? FINISH : REPLAY;
                    end else if (bus.push && bus.pop && !empty) begin
                        we = 1'b1;
                        wa = top;
                    end else if (bus.push && !full) begin
                        we   = 1'b1;
                        sp_d = sp + 1'b1;
                    end else if (bus.push && !bus.pop) begin
                        ovf_d = 1'b1;
                    end else if (bus.pop && !bus.push && !empty) begin
                        sp_d = sp - 1'b1;
                    end
                end
                REPLAY: begin
                    if (bus.dir_ready) begin
                        if (rp == top) state_d = FINISH;
                        else           rp_d    = rp + 1'b1;
                    end
                end
                FINISH: begin
                    if (bus.run) begin
                        rp_d    = '0;
                        state_d = REPLAY;
                    end
                end
                default: state_d = RECORD;
            endcase
        end
    end
endmodule

// File: tb/tb_maze_path_stack.sv
// tb_maze_path_stack: scoreboard bench; stimulus queues expected moves, a negedge monitor checks each transfer
module tb_maze_path_stack;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic [8:0] count;
    logic       empty, full, ovf;
    int         vec = 0;
    int         err = 0;
    int         xfers = 0;
    logic [1:0] exp_q [$];

    maze_path_stack_if bus ();

    maze_path_stack dut (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .bus   (bus.slave),
        .count (count),
        .empty (empty),
        .full  (full),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_dir(input logic [1:0] d, input bit expect_it);
        bus.push   = 1'b1;
        bus.dir_in = d;
        if (expect_it) exp_q.push_back(d);
        step();
        bus.push = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic start_run();
        bus.run = 1'b1;
        step();
        bus.run = 1'b0;
    endtask

    // monitor: every transfer must match the queue head; stalled outputs must keep showing the head
    always @(negedge clk) begin
        if (rst && bus.dir_valid) begin
            if (exp_q.size() == 0) begin
                vec++;
                err++;
                $display("FAIL unexpected_valid: got dir_out %0d with empty scoreboard at %0t", bus.dir_out, $time);
            end else if (bus.dir_ready) begin
                chk("xfer_dir", bus.dir_out, exp_q.pop_front());
                xfers++;
            end else begin
                chk("stall_dir", bus.dir_out, exp_q[0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish by 100000");
        $fatal(1);
    end

    initial begin
        logic [0:6] pat;
        int x0;
        pat           = 7'b1001101;
        bus.push      = 1'b0;
        bus.pop       = 1'b0;
        bus.dir_in    = 2'd0;
        bus.run       = 1'b0;
        bus.dir_ready = 1'b0;
        #12;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_valid", bus.dir_valid, 0);
        chk("rst_done", bus.replay_done, 0);
        chk("rst_dir_out", bus.dir_out, 0);
        rst = 1'b1;
        step();

        // basic record and replay of 3,1,2
        push_dir(2'd3, 1);
        push_dir(2'd1, 1);
        push_dir(2'd2, 1);
        chk("s1_count", count, 3);
        bus.dir_ready = 1'b1;
        start_run();
        chk("s1_first_valid", bus.dir_valid, 1);
        chk("s1_not_done", bus.replay_done, 0);
        repeat (3) step();
        chk("s1_done", bus.replay_done, 1);
        chk("s1_valid_low", bus.dir_valid, 0);
        chk("s1_drained", exp_q.size(), 0);
        do_clr();
        chk("s1_clr_empty", empty, 1);
        chk("s1_clr_done", bus.replay_done, 0);

        // pop, then replace-top via simultaneous push and pop
        push_dir(2'd0, 0);
        push_dir(2'd1, 0);
        push_dir(2'd2, 0);
        bus.pop = 1'b1;
        step();
        bus.pop = 1'b0;
        chk("s2_pop_count", count, 2);
        push_dir(2'd3, 0);
        bus.pop = 1'b1;
        push_dir(2'd2, 0);
        bus.pop = 1'b0;
        chk("s2_count", count, 3);
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        start_run();
        repeat (3) step();
        chk("s2_done", bus.replay_done, 1);
        chk("s2_drained", exp_q.size(), 0);
        do_clr();

        // backpressure: ready pattern 1,0,0,1,1,0,1 yields exactly 4 transfers
        for (int i = 0; i < 4; i++) push_dir(2'(i), 1);
        bus.dir_ready = 1'b0;
        start_run();
        x0 = xfers;
        for (int i = 0; i < 7; i++) begin
            bus.dir_ready = pat[i];
            if (i == 6) chk("s3_not_done_early", bus.replay_done, 0);
            step();
        end
        chk("s3_xfers", xfers - x0, 4);
        chk("s3_done", bus.replay_done, 1);
        chk("s3_drained", exp_q.size(), 0);
        bus.dir_ready = 1'b1;
        do_clr();

        // fill to capacity, overflow, replay all 256
        for (int i = 0; i < 256; i++) push_dir(2'(i), 1);
        chk("s4_full_pre", full, 1);
        chk("s4_ovf_pre", ovf, 0);
        push_dir(2'd0, 0);
        chk("s4_full", full, 1);
        chk("s4_count", count, 256);
        chk("s4_ovf", ovf, 1);
        start_run();
        repeat (255) step();
        chk("s4_last_dir", bus.dir_out, 3);
        step();
        chk("s4_done", bus.replay_done, 1);
        chk("s4_drained", exp_q.size(), 0);
        chk("s4_ovf_kept", ovf, 1);
        do_clr();
        chk("s4_clr_ovf", ovf, 0);
        chk("s4_clr_empty", empty, 1);
        chk("s4_clr_full", full, 0);

        // empty run and empty pop
        start_run();
        chk("s5_done", bus.replay_done, 1);
        chk("s5_valid", bus.dir_valid, 0);
        step();
        chk("s5_valid_hold", bus.dir_valid, 0);
        do_clr();
        bus.pop = 1'b1;
        step();
        bus.pop = 1'b0;
        chk("s5_pop_count", count, 0);
        chk("s5_pop_ovf", ovf, 0);

        // reset mid-replay after two transfers, then a fresh one-entry path
        for (int i = 0; i < 4; i++) push_dir(2'(i), 1);
        start_run();
        x0 = xfers;
        repeat (2) step();
        chk("s6_two_xfers", xfers - x0, 2);
        bus.dir_ready = 1'b0;
        rst = 1'b0;
        #2;
        chk("s6_rst_valid", bus.dir_valid, 0);
        chk("s6_rst_count", count, 0);
        chk("s6_rst_dir_out", bus.dir_out, 0);
        exp_q.delete();
        rst = 1'b1;
        step();
        chk("s6_record_done", bus.replay_done, 0);
        chk("s6_record_empty", empty, 1);
        push_dir(2'd1, 1);
        bus.dir_ready = 1'b1;
        x0 = xfers;
        start_run();
        step();
        chk("s6_done", bus.replay_done, 1);
        chk("s6_one_xfer", xfers - x0, 1);
        chk("s6_drained", exp_q.size(), 0);
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
